// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core sharing one instruction/data memory port.
// state    | meaning
// FETCH    | read instruction at PC, PC += 4
// DECODE   | latch A = reg[rs], B = reg[rt]
// EXEC     | ALU op, address calc, branch/jump resolution
// MEM      | data load/store at ALUOut
// WB       | register file write
// HALT     | terminal until reset
module mips_multicycle #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc_out,
    output logic        halted
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]  state;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] regs [0:31];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] simm, zimm, addr_sum, alu_result, wb_data;
    logic [4:0]  wb_idx;
    logic        is_rtype, is_add, is_and, is_nor, is_slt, is_sll, is_jr;
    logic        is_addi, is_andi, is_lw, is_sw, is_beq, is_jal, is_alu, legal;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign simm  = {{16{ir[15]}}, ir[15:0]};
    assign zimm  = {16'h0000, ir[15:0]};

    assign is_rtype = (op == 6'h00);
    assign is_add   = is_rtype && (funct == 6'h20);
    assign is_and   = is_rtype && (funct == 6'h24);
    assign is_nor   = is_rtype && (funct == 6'h27);
    assign is_slt   = is_rtype && (funct == 6'h2A);
    assign is_sll   = is_rtype && (funct == 6'h00);
    assign is_jr    = is_rtype && (funct == 6'h08);
    assign is_addi  = (op == 6'h08);
    assign is_andi  = (op == 6'h0C);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2B);
    assign is_beq   = (op == 6'h04);
    assign is_jal   = (op == 6'h03);
    assign is_alu   = is_add | is_and | is_nor | is_slt | is_sll | is_addi | is_andi;
    assign legal    = is_alu | is_jr | is_lw | is_sw | is_beq | is_jal;

    assign addr_sum = a + simm;
    assign wb_idx   = is_rtype ? rd : rt;
    assign wb_data  = is_lw ? mdr : alu_out;

    always_comb begin
        alu_result = '0;
        if (is_add)       alu_result = a + b;
        else if (is_and)  alu_result = a & b;
        else if (is_nor)  alu_result = ~(a | b);
        else if (is_slt)  alu_result = {31'd0, ($signed(a) < $signed(b))};
        else if (is_sll)  alu_result = b << shamt;
        else if (is_addi) alu_result = a + simm;
        else if (is_andi) alu_result = a & zimm;
    end

    // Gated by reset_n so an abandoned transaction drops the request immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset_n) begin
            if (state == S_FETCH && pc[1:0] == 2'b00) begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end else if (state == S_MEM) begin
                mem_req   = 1'b1;
                mem_addr  = alu_out;
                mem_we    = is_sw;
                mem_wdata = is_sw ? b : '0;
            end
        end
    end

    assign pc_out = pc;
    assign halted = (state == S_HALT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (pc[1:0] != 2'b00) begin
                        state <= S_HALT;
                    end else if (mem_ready) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 32'd4;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= regs[rs];
                    b     <= regs[rt];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (!legal) begin
                        state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end else if (is_beq) begin
                        if (a == b) pc <= pc + {simm[29:0], 2'b00};
                        state <= S_FETCH;
                    end else if (is_jal) begin
                        regs[31] <= pc;
                        pc       <= {pc[31:28], ir[25:0], 2'b00};
                        state    <= S_FETCH;
                    end else if (is_jr) begin
                        if (a[1:0] != 2'b00) begin
                            state <= S_HALT;
                        end else begin
                            pc    <= a;
                            state <= S_FETCH;
                        end
                    end else if (is_lw || is_sw) begin
                        if (addr_sum[1:0] != 2'b00) begin
                            state <= S_HALT;
                        end else begin
                            alu_out <= addr_sum;
                            state   <= S_MEM;
                        end
                    end else begin
                        alu_out <= alu_result;
                        state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_lw) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    if (wb_idx != 5'd0) regs[wb_idx] <= wb_data;
                    state <= S_FETCH;
                end
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
